// File: rtl/riscv_pkg.sv
// Shared encodings for the RV64 pipeline: load/store funct3, ResultSrc select and the
// memory-stage handshake FSM states.
package riscv_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_SD  = 3'b011;

    localparam logic [1:0] RESULT_ALU  = 2'b00;
    localparam logic [1:0] RESULT_LOAD = 2'b01;
    localparam logic [1:0] RESULT_PC4  = 2'b10;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } memState_t;

    // Address bits that must be zero for an access of the given size (funct3[1:0]).
    function automatic logic [2:0] accessMask(input logic [1:0] size);
        case (size)
            2'b00:   accessMask = 3'b000;
            2'b01:   accessMask = 3'b001;
            2'b10:   accessMask = 3'b011;
            default: accessMask = 3'b111;
        endcase
    endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load extractor: shifts the addressed byte lane down to bit 0 and
// sign- or zero-extends it according to the load funct3.
module load_align
    import riscv_pkg::*;
(
    input  logic [63:0] rdata,
    input  logic [2:0]  lane,
    input  logic [2:0]  funct3,
    output logic [63:0] loadValue
);

    logic [63:0] shifted;

    assign shifted = rdata >> {lane, 3'b000};

    always_comb begin
        loadValue = shifted;
        case (funct3)
            F3_LB:   loadValue = {{56{shifted[7]}},  shifted[7:0]};
            F3_LH:   loadValue = {{48{shifted[15]}}, shifted[15:0]};
            F3_LW:   loadValue = {{32{shifted[31]}}, shifted[31:0]};
            F3_LD:   loadValue = shifted;
            F3_LBU:  loadValue = {56'd0, shifted[7:0]};
            F3_LHU:  loadValue = {48'd0, shifted[15:0]};
            F3_LWU:  loadValue = {32'd0, shifted[31:0]};
            default: loadValue = shifted;
        endcase
    end

endmodule

// File: rtl/memory_access.sv
// Memory stage of the RV64 pipeline: EX/MEM and MEM/WB registers plus the data-memory
// handshake. Define MISALIGN_TRAP_EN to trap misaligned accesses instead of rounding them.
module memory_access
    import riscv_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [XLEN-1:0] ALUResultE,
    input  logic [XLEN-1:0] WriteDataE,
    input  logic [4:0]      RdE,
    input  logic [XLEN-1:0] PCPlus4E,
    input  logic            RegWriteE,
    input  logic            MemReadE,
    input  logic            MemWriteE,
    input  logic [1:0]      ResultSrcE,
    input  logic [2:0]      Funct3E,
    output logic [XLEN-1:0] ALUResultM,
    output logic [4:0]      RdM,
    output logic            RegWriteM,
    output logic            StallM,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    output logic [7:0]      dmem_wstrb,
    input  logic            dmem_ready,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic [XLEN-1:0] ALUResultW,
    output logic [XLEN-1:0] ReadDataW,
    output logic [XLEN-1:0] PCPlus4W,
    output logic [4:0]      RdW,
    output logic            RegWriteW,
    output logic [1:0]      ResultSrcW,
    output logic            TrapW
);

    logic [XLEN-1:0] WriteDataM;
    logic [XLEN-1:0] PCPlus4M;
    logic            MemReadM;
    logic            MemWriteM;
    logic [1:0]      ResultSrcM;
    logic [2:0]      Funct3M;

    memState_t       state;
    logic            memop;
    logic            memopEff;
    logic            trapNext;
    logic [2:0]      sizeMask;
    logic [XLEN-1:0] effAddr;
    logic [2:0]      lane;
    logic [7:0]      baseStrobe;
    logic [XLEN-1:0] loadValue;

    always_ff @(posedge clock) begin
        if (reset) begin
            ALUResultM <= '0;
            WriteDataM <= '0;
            RdM        <= '0;
            PCPlus4M   <= '0;
            RegWriteM  <= 1'b0;
            MemReadM   <= 1'b0;
            MemWriteM  <= 1'b0;
            ResultSrcM <= RESULT_ALU;
            Funct3M    <= '0;
        end else if (!StallM) begin
            ALUResultM <= ALUResultE;
            WriteDataM <= WriteDataE;
            RdM        <= RdE;
            PCPlus4M   <= PCPlus4E;
            RegWriteM  <= RegWriteE;
            MemReadM   <= MemReadE;
            MemWriteM  <= MemWriteE;
            ResultSrcM <= ResultSrcE;
            Funct3M    <= Funct3E;
        end
    end

    assign memop    = MemReadM | MemWriteM;
    assign sizeMask = accessMask(Funct3M[1:0]);

`ifdef MISALIGN_TRAP_EN
    logic misaligned;
    // A misaligned access never reaches the bus; it only produces a one-cycle trap in W.
    assign misaligned = |(ALUResultM[2:0] & sizeMask);
    assign memopEff   = memop & ~misaligned;
    assign trapNext   = memop & misaligned;
    assign effAddr    = ALUResultM;
`else
    assign memopEff   = memop;
    assign trapNext   = 1'b0;
    assign effAddr    = {ALUResultM[XLEN-1:3], ALUResultM[2:0] & ~sizeMask};
`endif

    assign lane       = effAddr[2:0];
    assign StallM     = memopEff & ~dmem_ready;
    assign dmem_req   = memopEff | (state == WAIT);
    assign dmem_we    = MemWriteM;
    assign dmem_addr  = {effAddr[XLEN-1:3], 3'b000};
    assign dmem_wstrb = baseStrobe << lane;

    always_comb begin
        baseStrobe = 8'hFF;
        dmem_wdata = WriteDataM;
        case (Funct3M[1:0])
            2'b00: begin
                baseStrobe = 8'h01;
                dmem_wdata = {8{WriteDataM[7:0]}};
            end
            2'b01: begin
                baseStrobe = 8'h03;
                dmem_wdata = {4{WriteDataM[15:0]}};
            end
            2'b10: begin
                baseStrobe = 8'h0F;
                dmem_wdata = {2{WriteDataM[31:0]}};
            end
            default: begin
                baseStrobe = 8'hFF;
                dmem_wdata = WriteDataM;
            end
        endcase
    end

    load_align uLoadAlign (
        .rdata     (dmem_rdata),
        .lane      (lane),
        .funct3    (Funct3M),
        .loadValue (loadValue)
    );

    // Address, data and strobes all derive from the held M register, so they stay stable in WAIT.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (memopEff && !dmem_ready) state <= WAIT;
                WAIT:    if (dmem_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ALUResultW <= '0;
            ReadDataW  <= '0;
            PCPlus4W   <= '0;
            RdW        <= '0;
            RegWriteW  <= 1'b0;
            ResultSrcW <= RESULT_ALU;
            TrapW      <= 1'b0;
        end else if (StallM) begin
            RdW        <= '0;
            RegWriteW  <= 1'b0;
            TrapW      <= 1'b0;
        end else begin
            ALUResultW <= ALUResultM;
            ReadDataW  <= loadValue;
            PCPlus4W   <= PCPlus4M;
            RdW        <= RdM;
            RegWriteW  <= RegWriteM & ~trapNext;
            ResultSrcW <= ResultSrcM;
            TrapW      <= trapNext;
        end
    end

endmodule

// File: tb/tb_memory_access.sv
// Directed bench for memory_access with hand-computed expectations; honours MISALIGN_TRAP_EN.
module tb_memory_access;

    logic        clock = 1'b0;
    logic        reset;
    logic [63:0] ALUResultE, WriteDataE, PCPlus4E;
    logic [4:0]  RdE;
    logic        RegWriteE, MemReadE, MemWriteE;
    logic [1:0]  ResultSrcE;
    logic [2:0]  Funct3E;
    logic [63:0] ALUResultM;
    logic [4:0]  RdM;
    logic        RegWriteM, StallM;
    logic        dmem_req, dmem_we, dmem_ready;
    logic [63:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [7:0]  dmem_wstrb;
    logic [63:0] ALUResultW, ReadDataW, PCPlus4W;
    logic [4:0]  RdW;
    logic        RegWriteW, TrapW;
    logic [1:0]  ResultSrcW;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    memory_access dut (
        .clock(clock), .reset(reset),
        .ALUResultE(ALUResultE), .WriteDataE(WriteDataE), .RdE(RdE), .PCPlus4E(PCPlus4E),
        .RegWriteE(RegWriteE), .MemReadE(MemReadE), .MemWriteE(MemWriteE),
        .ResultSrcE(ResultSrcE), .Funct3E(Funct3E),
        .ALUResultM(ALUResultM), .RdM(RdM), .RegWriteM(RegWriteM), .StallM(StallM),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
        .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
        .ALUResultW(ALUResultW), .ReadDataW(ReadDataW), .PCPlus4W(PCPlus4W),
        .RdW(RdW), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .TrapW(TrapW)
    );

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [63:0] alu, input logic [63:0] wdata, input logic [4:0] rd,
                                 input logic regw, input logic mr, input logic mw,
                                 input logic [1:0] rsrc, input logic [2:0] f3);
        ALUResultE = alu;
        WriteDataE = wdata;
        RdE        = rd;
        PCPlus4E   = alu + 64'd4;
        RegWriteE  = regw;
        MemReadE   = mr;
        MemWriteE  = mw;
        ResultSrcE = rsrc;
        Funct3E    = f3;
    endtask

    task automatic nop();
        applyStimulus(64'd0, 64'd0, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        dmem_ready = 1'b0;
        dmem_rdata = 64'd0;
        nop();
        step();
        step();
        reset = 1'b0;
        @(negedge clock);
        checkOutput("resetReq", dmem_req, 1'b0);
        checkOutput("resetStall", StallM, 1'b0);
        checkOutput("resetAluM", ALUResultM, 64'd0);
        checkOutput("resetRegWriteW", RegWriteW, 1'b0);
        checkOutput("resetTrapW", TrapW, 1'b0);

        // Plain ALU op passes through in one cycle per stage.
        step();
        applyStimulus(64'h1234, 64'd0, 5'd5, 1'b1, 1'b0, 1'b0, 2'b00, 3'b000);
        step();
        nop();
        @(negedge clock);
        checkOutput("aluM", ALUResultM, 64'h1234);
        checkOutput("aluReqM", dmem_req, 1'b0);
        step();
        @(negedge clock);
        checkOutput("aluW", ALUResultW, 64'h1234);
        checkOutput("aluRdW", RdW, 5'd5);
        checkOutput("aluRegWriteW", RegWriteW, 1'b1);
        checkOutput("aluReqW", dmem_req, 1'b0);

        // SB to lane 3 with zero wait.
        step();
        applyStimulus(64'h1003, 64'hAB, 5'd0, 1'b0, 1'b0, 1'b1, 2'b00, 3'b000);
        dmem_ready = 1'b1;
        step();
        nop();
        @(negedge clock);
        checkOutput("sbReq", dmem_req, 1'b1);
        checkOutput("sbWe", dmem_we, 1'b1);
        checkOutput("sbAddr", dmem_addr, 64'h1000);
        checkOutput("sbStrb", dmem_wstrb, 8'h08);
        checkOutput("sbData", dmem_wdata, 64'hABAB_ABAB_ABAB_ABAB);
        checkOutput("sbStall", StallM, 1'b0);

        // SH to lane 6 and SW to lane 4.
        step();
        applyStimulus(64'h100E, 64'h1234_5678_9ABC_DEF0, 5'd0, 1'b0, 1'b0, 1'b1, 2'b00, 3'b001);
        step();
        applyStimulus(64'h1004, 64'h1234_5678_9ABC_DEF0, 5'd0, 1'b0, 1'b0, 1'b1, 2'b00, 3'b010);
        @(negedge clock);
        checkOutput("shStrb", dmem_wstrb, 8'hC0);
        checkOutput("shData", dmem_wdata, 64'hDEF0_DEF0_DEF0_DEF0);
        step();
        nop();
        @(negedge clock);
        checkOutput("swStrb", dmem_wstrb, 8'hF0);
        checkOutput("swData", dmem_wdata, 64'h9ABC_DEF0_9ABC_DEF0);
        checkOutput("swAddr", dmem_addr, 64'h1000);
        step();
        dmem_ready = 1'b0;

        // LH at lane 6 with three wait cycles.
        applyStimulus(64'h2006, 64'd0, 5'd7, 1'b1, 1'b1, 1'b0, 2'b01, 3'b001);
        step();
        nop();
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            checkOutput("lhStall", StallM, 1'b1);
            checkOutput("lhReq", dmem_req, 1'b1);
            checkOutput("lhAddrHeld", dmem_addr, 64'h2000);
            checkOutput("lhBubbleW", RegWriteW, 1'b0);
            step();
        end
        dmem_ready = 1'b1;
        dmem_rdata = 64'h8001_0000_0000_0000;
        @(negedge clock);
        checkOutput("lhStallDone", StallM, 1'b0);
        step();
        @(negedge clock);
        checkOutput("lhData", ReadDataW, 64'hFFFF_FFFF_FFFF_8001);
        checkOutput("lhRdW", RdW, 5'd7);
        checkOutput("lhRegWriteW", RegWriteW, 1'b1);
        checkOutput("lhResultSrcW", ResultSrcW, 2'b01);

        // LWU at lane 4, zero wait.
        applyStimulus(64'h3004, 64'd0, 5'd8, 1'b1, 1'b1, 1'b0, 2'b01, 3'b110);
        dmem_rdata = 64'hF000_0000_0000_0000;
        step();
        nop();
        @(negedge clock);
        checkOutput("lwuStall", StallM, 1'b0);
        checkOutput("lwuAddr", dmem_addr, 64'h3000);
        step();
        @(negedge clock);
        checkOutput("lwuData", ReadDataW, 64'h0000_0000_F000_0000);

        // LB and LBU at lane 7.
        applyStimulus(64'h0007, 64'd0, 5'd10, 1'b1, 1'b1, 1'b0, 2'b01, 3'b000);
        dmem_rdata = 64'h8000_0000_0000_0000;
        step();
        applyStimulus(64'h0007, 64'd0, 5'd11, 1'b1, 1'b1, 1'b0, 2'b01, 3'b100);
        step();
        nop();
        @(negedge clock);
        checkOutput("lbData", ReadDataW, 64'hFFFF_FFFF_FFFF_FF80);
        step();
        @(negedge clock);
        checkOutput("lbuData", ReadDataW, 64'h0000_0000_0000_0080);

        // Reset while an LD sits in WAIT.
        dmem_ready = 1'b0;
        applyStimulus(64'h5000, 64'd0, 5'd3, 1'b1, 1'b1, 1'b0, 2'b01, 3'b011);
        step();
        nop();
        @(negedge clock);
        checkOutput("ldStall", StallM, 1'b1);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clock);
        checkOutput("rstWaitReq", dmem_req, 1'b0);
        checkOutput("rstWaitStall", StallM, 1'b0);
        checkOutput("rstWaitRegWriteW", RegWriteW, 1'b0);

        // LW at 0x4002: trap or round down depending on build.
        dmem_ready = 1'b1;
        dmem_rdata = 64'h1111_2222_8765_4321;
        applyStimulus(64'h4002, 64'd0, 5'd9, 1'b1, 1'b1, 1'b0, 2'b01, 3'b010);
        step();
        nop();
`ifdef MISALIGN_TRAP_EN
        dmem_ready = 1'b0;
        @(negedge clock);
        checkOutput("misReq", dmem_req, 1'b0);
        checkOutput("misStall", StallM, 1'b0);
        step();
        @(negedge clock);
        checkOutput("misTrapW", TrapW, 1'b1);
        checkOutput("misRegWriteW", RegWriteW, 1'b0);
        step();
        @(negedge clock);
        checkOutput("misTrapClear", TrapW, 1'b0);
`else
        @(negedge clock);
        checkOutput("misReq", dmem_req, 1'b1);
        checkOutput("misAddr", dmem_addr, 64'h4000);
        step();
        @(negedge clock);
        checkOutput("misData", ReadDataW, 64'hFFFF_FFFF_8765_4321);
        checkOutput("misTrapW", TrapW, 1'b0);
        checkOutput("misRegWriteW", RegWriteW, 1'b1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
